wb_stage_pipelined: RTL and testbench

Parametrised write-back stage with a MEM/WB pipeline register and a valid/ready handshake. Its load path extracts and sign/zero-extends the addressed lane of the memory doubleword, with misaligned and illegal-width detection. It selects one of four result sources, drives the register-file write port and a forwarding bus, and counts retired instructions. It sits between the memory stage and the register file in the pipelined core.

---
 rtl/wb_stage_pipelined_pkg.sv | 20 ++
 rtl/wb_stage_pipelined_load_extend.sv | 50 +++++
 rtl/wb_stage_pipelined.sv | 123 ++++++++++++
 tb/tb_wb_stage_pipelined.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pipelined_pkg.sv
// Shared encodings for the write-back result select and load funct3 values,
// used by decode, the MEM stage and the write-back stage.
package wb_stage_pipelined_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_pipelined_load_extend.sv
// Combinational load lane extraction: shifts the addressed lane down, then
// sign- or zero-extends it and flags misaligned or illegal load widths.
module load_extend
    import wb_stage_pipelined_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int AW = $clog2(XLEN / 8)
) (
    input  logic [2:0]      funct3_i,
    input  logic [AW-1:0]   addr_lo_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o,
    output logic            trap_o
);

    localparam int SW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] left;
    logic [SW-1:0]   pad;

    // Left-align the lane, then shift back so the top bit sets the extension.
    always_comb begin
        shifted = data_i >> {addr_lo_i, 3'b000};
        case (funct3_i[1:0])
            2'b00:   pad = SW'(XLEN - 8);
            2'b01:   pad = SW'(XLEN - 16);
            2'b10:   pad = SW'(XLEN - 32);
            default: pad = '0;
        endcase
        left = shifted << pad;
        if (funct3_i[2])
            data_o = left >> pad;
        else
            data_o = $signed(left) >>> pad;
    end

    always_comb begin
        trap_o = 1'b0;
        case (funct3_i)
            F3_LB, F3_LBU: trap_o = 1'b0;
            F3_LH, F3_LHU: trap_o = addr_lo_i[0];
            F3_LW:         trap_o = (addr_lo_i[1:0] != 2'b00);
            F3_LWU:        trap_o = (addr_lo_i[1:0] != 2'b00) || (XLEN == 32);
            F3_LD:         trap_o = (addr_lo_i != '0) || (XLEN == 32);
            default:       trap_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Write-back stage: MEM/WB register with valid/ready handshake, result select,
// register-file write port, forwarding bus and retired-instruction counter.
module wb_stage_pipelined
    import wb_stage_pipelined_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int REG_AW   = 5,
    parameter int RETIRE_W = 64,
    parameter int DEBUG    = 0,
    localparam int AW = $clog2(XLEN / 8)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          wb_sel,
    input  logic                reg_write,
    input  logic [REG_AW-1:0]   rd,
    input  logic [2:0]          funct3,
    input  logic [AW-1:0]       addr_lo,
    input  logic [XLEN-1:0]     read_data,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     pc_plus4,
    input  logic [XLEN-1:0]     imm,
    input  logic                stall,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic                fwd_valid,
    output logic [REG_AW-1:0]   fwd_rd,
    output logic [XLEN-1:0]     fwd_data,
    output logic                load_trap,
    output logic [RETIRE_W-1:0] retire_count
);

    generate
        if ((XLEN != 32 && XLEN != 64) || (DEBUG != 0 && DEBUG != 1)) begin : g_bad_param
            $error("wb_stage_pipelined: unsupported XLEN or DEBUG value");
        end
    endgenerate

    logic [XLEN-1:0] load_data;
    logic            load_trap_raw;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3_i  (funct3),
        .addr_lo_i (addr_lo),
        .data_i    (read_data),
        .data_o    (load_data),
        .trap_o    (load_trap_raw)
    );

    logic                valid_q, valid_d;
    logic                reg_write_q, reg_write_d;
    logic                trap_q, trap_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [RETIRE_W-1:0] retire_q, retire_d;

    logic xfer;
    logic commit;
    logic result_ok;

    // Reset gates the handshake so nothing is accepted or committed mid-reset.
    assign in_ready  = !reset && !flush && (!valid_q || !stall);
    assign xfer      = in_valid && in_ready;
    assign commit    = !reset && valid_q && !stall;
    assign result_ok = valid_q && reg_write_q && (rd_q != '0) && !trap_q;

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        trap_d      = trap_q;
        rd_d        = rd_q;
        data_d      = data_q;
        retire_d    = retire_q;
        if (xfer) begin
            valid_d     = 1'b1;
            reg_write_d = reg_write;
            rd_d        = rd;
            trap_d      = (wb_sel == WB_MEM) && load_trap_raw;
            case (wb_sel_e'(wb_sel))
                WB_ALU:  data_d = alu_result;
                WB_MEM:  data_d = load_data;
                WB_PC4:  data_d = pc_plus4;
                default: data_d = imm;
            endcase
        end else if (commit || flush) begin
            valid_d = 1'b0;
        end
        if (commit && !trap_q)
            retire_d = retire_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            trap_q      <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            retire_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            trap_q      <= trap_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            retire_q    <= retire_d;
        end
    end

    assign rf_we        = commit && result_ok;
    assign rf_waddr     = rd_q;
    assign rf_wdata     = data_q;
    assign fwd_valid    = !reset && result_ok;
    assign fwd_rd       = rd_q;
    assign fwd_data     = data_q;
    assign load_trap    = commit && trap_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined: a 64-bit instance with a 64-bit retire
// counter and a second instance with a 4-bit counter sharing the same inputs.
module tb_wb_stage_pipelined;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [1:0]  wb_sel;
    logic        reg_write;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [2:0]  addr_lo;
    logic [63:0] read_data;
    logic [63:0] alu_result;
    logic [63:0] pc_plus4;
    logic [63:0] imm;
    logic        stall;

    logic        in_ready, rf_we, fwd_valid, load_trap;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [63:0] rf_wdata, fwd_data, retire_count;

    logic        in_ready4, rf_we4, fwd_valid4, load_trap4;
    logic [4:0]  rf_waddr4, fwd_rd4;
    logic [63:0] rf_wdata4, fwd_data4;
    logic [3:0]  retire_count4;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage_pipelined #(.XLEN(64), .REG_AW(5), .RETIRE_W(64), .DEBUG(0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .reg_write(reg_write), .rd(rd), .funct3(funct3), .addr_lo(addr_lo),
        .read_data(read_data), .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_trap(load_trap), .retire_count(retire_count)
    );

    wb_stage_pipelined #(.XLEN(64), .REG_AW(5), .RETIRE_W(4), .DEBUG(0)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .wb_sel(wb_sel), .reg_write(reg_write), .rd(rd), .funct3(funct3), .addr_lo(addr_lo),
        .read_data(read_data), .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm),
        .stall(stall), .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .fwd_valid(fwd_valid4), .fwd_rd(fwd_rd4), .fwd_data(fwd_data4),
        .load_trap(load_trap4), .retire_count(retire_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic rw, input logic [4:0] r,
                         input logic [2:0] f3, input logic [2:0] alo, input logic [63:0] val);
        in_valid   = 1'b1;
        wb_sel     = sel;
        reg_write  = rw;
        rd         = r;
        funct3     = f3;
        addr_lo    = alo;
        read_data  = val;
        alu_result = val;
        pc_plus4   = val;
        imm        = val;
    endtask

    task automatic send(input logic [1:0] sel, input logic rw, input logic [4:0] r,
                        input logic [2:0] f3, input logic [2:0] alo, input logic [63:0] val);
        drive(sel, rw, r, f3, alo, val);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
        wb_sel = 2'd0; reg_write = 1'b0; rd = '0; funct3 = '0; addr_lo = '0;
        read_data = '0; alu_result = '0; pc_plus4 = '0; imm = '0;
        tick();
        in_valid = 1'b1;
        tick();
        check("reset_rf_we", rf_we, 0);
        check("reset_fwd_valid", fwd_valid, 0);
        check("reset_retire", retire_count, 0);
        check("reset_in_ready", in_ready, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_no_commit", rf_we, 0);

        send(2'd0, 1'b1, 5'd5, 3'b000, 3'd0, 64'h2A);
        check("alu_rf_we", rf_we, 1);
        check("alu_waddr", rf_waddr, 5);
        check("alu_wdata", rf_wdata, 64'h2A);
        tick();
        check("alu_retire", retire_count, 1);
        check("alu_idle_we", rf_we, 0);

        send(2'd1, 1'b1, 5'd6, 3'b000, 3'd3, 64'h0000_0000_8000_0000);
        check("lb_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        tick();
        send(2'd1, 1'b1, 5'd6, 3'b100, 3'd3, 64'h0000_0000_8000_0000);
        check("lbu_wdata", rf_wdata, 64'h80);
        tick();
        send(2'd1, 1'b1, 5'd8, 3'b001, 3'd6, 64'h8001_0000_0000_0000);
        check("lh_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_8001);
        tick();
        check("loads_retire", retire_count, 4);

        send(2'd1, 1'b1, 5'd6, 3'b010, 3'd2, 64'h1234);
        check("lw_mis_trap", load_trap, 1);
        check("lw_mis_we", rf_we, 0);
        check("lw_mis_fwd", fwd_valid, 0);
        tick();
        check("lw_mis_trap_pulse", load_trap, 0);
        check("lw_mis_retire", retire_count, 4);

        send(2'd1, 1'b1, 5'd7, 3'b011, 3'd0, 64'h1122_3344_5566_7788);
        check("ld_trap", load_trap, 0);
        check("ld_we", rf_we, 1);
        check("ld_wdata", rf_wdata, 64'h1122_3344_5566_7788);
        tick();
        check("ld_retire", retire_count, 5);

        stall = 1'b1;
        send(2'd0, 1'b1, 5'd9, 3'b000, 3'd0, 64'h55);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_we", rf_we, 0);
            check("stall_fwd", fwd_valid, 1);
            tick();
        end
        stall = 1'b0;
        #1;
        check("release_we", rf_we, 1);
        check("release_wdata", rf_wdata, 64'h55);
        tick();
        check("release_single", rf_we, 0);
        check("release_ready", in_ready, 1);
        check("release_retire", retire_count, 6);

        send(2'd0, 1'b1, 5'd0, 3'b000, 3'd0, 64'h99);
        check("rd0_we", rf_we, 0);
        check("rd0_fwd", fwd_valid, 0);
        tick();
        check("rd0_retire", retire_count, 7);

        stall = 1'b1;
        send(2'd0, 1'b1, 5'd3, 3'b000, 3'd0, 64'h77);
        flush = 1'b1;
        drive(2'd0, 1'b1, 5'd4, 3'b000, 3'd0, 64'h66);
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        stall = 1'b0;
        #1;
        check("flush_we", rf_we, 0);
        check("flush_fwd", fwd_valid, 0);
        tick();
        check("flush_retire", retire_count, 7);

        drive(2'd0, 1'b1, 5'd10, 3'b000, 3'd0, 64'hA0);
        tick();
        check("stream0_we", rf_we, 1);
        check("stream0_wdata", rf_wdata, 64'hA0);
        drive(2'd2, 1'b1, 5'd11, 3'b000, 3'd0, 64'hB4);
        tick();
        check("stream1_we", rf_we, 1);
        check("stream1_wdata", rf_wdata, 64'hB4);
        drive(2'd3, 1'b1, 5'd12, 3'b000, 3'd0, 64'hC000);
        tick();
        check("stream2_we", rf_we, 1);
        check("stream2_waddr", rf_waddr, 12);
        drive(2'd0, 1'b1, 5'd13, 3'b000, 3'd0, 64'hD0);
        tick();
        check("stream3_we", rf_we, 1);
        check("stream3_fwd_rd", fwd_rd, 13);
        in_valid = 1'b0;
        tick();
        check("stream_retire", retire_count, 11);
        check("narrow_retire", retire_count4, 11);

        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 1'b1, 5'd1, 3'b000, 3'd0, 64'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("narrow_max", retire_count4, 15);
        send(2'd0, 1'b1, 5'd2, 3'b000, 3'd0, 64'h1);
        tick();
        check("narrow_wrap", retire_count4, 0);
        check("wide_after_wrap", retire_count, 16);

        stall = 1'b1;
        send(2'd0, 1'b1, 5'd2, 3'b000, 3'd0, 64'h5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        check("reset_stall_we", rf_we, 0);
        check("reset_stall_retire", retire_count, 0);
        tick();
        check("reset_stall_drop", retire_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
